// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter between VGA scanout reads and a drawing engine.
// Optional starvation guard for the drawing port is enabled by defining VGA_FB_ARB_STARVE_GUARD_EN.
module vga_fb_arbiter #(
  parameter int ADDR_BITS    = 17,
  parameter int DATA_BITS    = 12,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 blank,
  input  logic                 scan_req,
  input  logic [ADDR_BITS-1:0] scan_addr,
  output logic                 scan_gnt,
  output logic                 scan_rvalid,
  output logic [DATA_BITS-1:0] scan_rdata,
  input  logic                 draw_valid,
  input  logic                 draw_we,
  input  logic [ADDR_BITS-1:0] draw_addr,
  input  logic [DATA_BITS-1:0] draw_wdata,
  output logic                 draw_ready,
  output logic                 draw_rvalid,
  output logic [DATA_BITS-1:0] draw_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_wdata,
  input  logic [DATA_BITS-1:0] ram_rdata
);

  typedef enum logic [1:0] {TAG_NONE, TAG_SCAN, TAG_DRAW} tag_e;

  tag_e tag_q, tag_d;
  logic scan_win, draw_win, draw_first;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_limit_check
    $error("vga_fb_arbiter: STARVE_LIMIT must be in 1..255");
  end

`ifdef VGA_FB_ARB_STARVE_GUARD_EN
  typedef enum logic {ST_NORMAL, ST_FORCE} state_e;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_NORMAL;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // A FORCE cycle lasts exactly one cycle whether or not the drawing port uses it.
  always_comb begin
    state_d = ST_NORMAL;
    count_d = 8'd0;
    if (state_q == ST_NORMAL && draw_valid && !draw_win) begin
      count_d = (count_q >= LIMIT) ? LIMIT : count_q + 8'd1;
      if (count_d == LIMIT) state_d = ST_FORCE;
    end
  end

  assign draw_first = blank || (state_q == ST_FORCE);
`else
  assign draw_first = blank;
`endif

  // Grants are gated by reset so nothing reaches the RAM while held in reset.
  always_comb begin
    scan_win = 1'b0;
    draw_win = 1'b0;
    if (aresetn) begin
      if (draw_first && draw_valid) draw_win = 1'b1;
      else if (scan_req)            scan_win = 1'b1;
      else if (draw_valid)          draw_win = 1'b1;
    end
  end

  always_comb begin
    ram_en    = scan_win || draw_win;
    ram_we    = draw_win && draw_we;
    ram_addr  = draw_win ? draw_addr : scan_addr;
    ram_wdata = draw_wdata;
    tag_d     = TAG_NONE;
    if (scan_win)                 tag_d = TAG_SCAN;
    else if (draw_win && !draw_we) tag_d = TAG_DRAW;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) tag_q <= TAG_NONE;
    else          tag_q <= tag_d;
  end

  assign scan_gnt    = scan_win;
  assign draw_ready  = draw_win;
  assign scan_rvalid = aresetn && (tag_q == TAG_SCAN);
  assign draw_rvalid = aresetn && (tag_q == TAG_DRAW);
  assign scan_rdata  = ram_rdata;
  assign draw_rdata  = ram_rdata;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: directed vector table, reset/starvation sequences and
// randomized traffic checked against a rule-level reference model.
module tb_vga_fb_arbiter;

  localparam int AW    = 17;
  localparam int DW    = 12;
  localparam int LIMIT = 8;
`ifdef VGA_FB_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic          blank;
    logic          scanReq;
    logic [AW-1:0] scanAddr;
    logic          drawValid;
    logic          drawWe;
    logic [AW-1:0] drawAddr;
    logic [DW-1:0] drawWdata;
    logic          chk;
    logic          expScanGnt;
    logic          expDrawReady;
    logic          expRamWe;
    logic [AW-1:0] expRamAddr;
  } vecT;

  logic          clk, aresetn, blank;
  logic          scan_req, scan_gnt, scan_rvalid;
  logic [AW-1:0] scan_addr;
  logic [DW-1:0] scan_rdata;
  logic          draw_valid, draw_we, draw_ready, draw_rvalid;
  logic [AW-1:0] draw_addr;
  logic [DW-1:0] draw_wdata, draw_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int nVec = 0;
  int nErr = 0;

  // Reference model state
  int            mStall;
  logic          mPendScan, mPendDraw;
  logic [AW-1:0] mPendAddr;
  logic [DW-1:0] mMem [int];
  logic          lastDrawReady;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  vga_fb_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .aresetn(aresetn), .blank(blank),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt),
    .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
    .draw_valid(draw_valid), .draw_we(draw_we), .draw_addr(draw_addr),
    .draw_wdata(draw_wdata), .draw_ready(draw_ready), .draw_rvalid(draw_rvalid),
    .draw_rdata(draw_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] initVal(int a);
    return DW'((a * 37 + 5) & 'hFFF);
  endfunction

  function automatic logic [DW-1:0] modelRead(int a);
    return mMem.exists(a) ? mMem[a] : initVal(a);
  endfunction

  // Synchronous single-port RAM with one cycle read latency
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = initVal(i);
    ram_rdata = '0;
  end
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAllLow(input string tag);
    checkOutput({tag, "_scan_gnt"},    32'(scan_gnt),    32'd0);
    checkOutput({tag, "_scan_rvalid"}, 32'(scan_rvalid), 32'd0);
    checkOutput({tag, "_draw_ready"},  32'(draw_ready),  32'd0);
    checkOutput({tag, "_draw_rvalid"}, 32'(draw_rvalid), 32'd0);
    checkOutput({tag, "_ram_en"},      32'(ram_en),      32'd0);
    checkOutput({tag, "_ram_we"},      32'(ram_we),      32'd0);
  endtask

  // One clock cycle: called just after a rising edge, returns just after the next one.
  task automatic applyStimulus(input vecT v);
    logic forced, drawFirst, eScan, eDraw;
    blank      = v.blank;
    scan_req   = v.scanReq;
    scan_addr  = v.scanAddr;
    draw_valid = v.drawValid;
    draw_we    = v.drawWe;
    draw_addr  = v.drawAddr;
    draw_wdata = v.drawWdata;
    @(negedge clk);

    forced    = GUARD && (mStall >= LIMIT);
    drawFirst = v.blank || forced;
    eScan     = 1'b0;
    eDraw     = 1'b0;
    if (drawFirst && v.drawValid) eDraw = 1'b1;
    else if (v.scanReq)           eScan = 1'b1;
    else if (v.drawValid)         eDraw = 1'b1;

    checkOutput("scan_gnt",    32'(scan_gnt),    32'(eScan));
    checkOutput("draw_ready",  32'(draw_ready),  32'(eDraw));
    checkOutput("ram_en",      32'(ram_en),      32'(eScan | eDraw));
    checkOutput("ram_we",      32'(ram_we),      32'(eDraw & v.drawWe));
    if (eScan) checkOutput("ram_addr_scan", 32'(ram_addr), 32'(v.scanAddr));
    if (eDraw) checkOutput("ram_addr_draw", 32'(ram_addr), 32'(v.drawAddr));
    if (eDraw && v.drawWe) checkOutput("ram_wdata", 32'(ram_wdata), 32'(v.drawWdata));
    checkOutput("scan_rvalid", 32'(scan_rvalid), 32'(mPendScan));
    checkOutput("draw_rvalid", 32'(draw_rvalid), 32'(mPendDraw));
    if (mPendScan) checkOutput("scan_rdata", 32'(scan_rdata), 32'(modelRead(int'(mPendAddr))));
    if (mPendDraw) checkOutput("draw_rdata", 32'(draw_rdata), 32'(modelRead(int'(mPendAddr))));
    if (v.chk) begin
      checkOutput("tbl_scan_gnt",   32'(scan_gnt),   32'(v.expScanGnt));
      checkOutput("tbl_draw_ready", 32'(draw_ready), 32'(v.expDrawReady));
      checkOutput("tbl_ram_we",     32'(ram_we),     32'(v.expRamWe));
      if (v.expScanGnt || v.expDrawReady)
        checkOutput("tbl_ram_addr", 32'(ram_addr), 32'(v.expRamAddr));
    end
    lastDrawReady = draw_ready;

    mPendScan = eScan;
    mPendDraw = eDraw && !v.drawWe;
    mPendAddr = eScan ? v.scanAddr : v.drawAddr;
    if (eDraw && v.drawWe) mMem[int'(v.drawAddr)] = v.drawWdata;
    if (forced || !v.drawValid || eDraw) mStall = 0;
    else mStall = (mStall + 1 > LIMIT) ? LIMIT : mStall + 1;

    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    aresetn    = 1'b0;
    blank      = 1'b0;
    scan_req   = 1'b1;
    scan_addr  = 17'h00001;
    draw_valid = 1'b1;
    draw_we    = 1'b1;
    draw_addr  = 17'h00002;
    draw_wdata = 12'h000;
    #1;
    checkAllLow("reset");
    @(posedge clk);
    #1;
    mStall    = 0;
    mPendScan = 1'b0;
    mPendDraw = 1'b0;
    mPendAddr = '0;
    aresetn   = 1'b1;
  endtask

  function automatic vecT mk(logic b, logic sr, int sa, logic dv, logic dwe, int da, int dd,
                             logic c, logic es, logic ed, logic ew, int ea);
    vecT v;
    v.blank = b; v.scanReq = sr; v.scanAddr = AW'(sa);
    v.drawValid = dv; v.drawWe = dwe; v.drawAddr = AW'(da); v.drawWdata = DW'(dd);
    v.chk = c; v.expScanGnt = es; v.expDrawReady = ed; v.expRamWe = ew; v.expRamAddr = AW'(ea);
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecT tbl[$];
    vecT rv;
    int  draws;

    // blank scan  saddr  draw  we  daddr  wdata   chk sGnt dRdy we  ramAddr
    tbl.push_back(mk(0, 1, 'h10, 1, 0, 'h05, 'h000, 1, 1, 0, 0, 'h10));
    tbl.push_back(mk(1, 1, 'h10, 1, 1, 'h20, 'hF0F, 1, 0, 1, 1, 'h20));
    tbl.push_back(mk(0, 1, 'h20, 0, 0, 'h00, 'h000, 1, 1, 0, 0, 'h20));
    tbl.push_back(mk(0, 0, 'h00, 1, 0, 'h05, 'h000, 1, 0, 1, 0, 'h05));
    tbl.push_back(mk(0, 1, 'h05, 0, 0, 'h00, 'h000, 1, 1, 0, 0, 'h05));
    tbl.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 'h000, 1, 0, 0, 0, 'h00));
    tbl.push_back(mk(1, 1, 'h07, 0, 0, 'h00, 'h000, 1, 1, 0, 0, 'h07));
    tbl.push_back(mk(0, 0, 'h00, 1, 1, 'h07, 'h123, 1, 0, 1, 1, 'h07));
    tbl.push_back(mk(0, 1, 'h07, 0, 0, 'h00, 'h000, 1, 1, 0, 0, 'h07));
    tbl.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 'h000, 1, 0, 0, 0, 'h00));

    doReset();
    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

    // Reset while a scan read is in flight: its rvalid must never appear.
    applyStimulus(mk(0, 1, 'h30, 0, 0, 0, 0, 1, 1, 0, 0, 'h30));
    aresetn = 1'b0;
    #1;
    checkAllLow("inflight_reset");
    @(negedge clk);
    checkAllLow("held_reset");
    @(posedge clk);
    #1;
    mStall = 0; mPendScan = 1'b0; mPendDraw = 1'b0;
    aresetn = 1'b1;
    applyStimulus(mk(0, 1, 'h31, 0, 0, 0, 0, 1, 1, 0, 0, 'h31));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    // Continuous contention with blank low: drawing port only wins through the guard.
    doReset();
    draws = 0;
    for (int i = 0; i < 3 * (LIMIT + 1); i++) begin
      applyStimulus(mk(0, 1, i, 1, 0, 'h40 + i, 0, 0, 0, 0, 0, 0));
      if (lastDrawReady) draws++;
    end
    checkOutput("starve_draw_count", 32'(draws), GUARD ? 32'd3 : 32'd0);

    // Randomized traffic over a small address window to exercise read-after-write.
    doReset();
    for (int i = 0; i < 400; i++) begin
      rv = mk($urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 15),
              $urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 15),
              $urandom_range(0, 4095), 0, 0, 0, 0, 0);
      applyStimulus(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
